// File: rtl/counter_sweep_ctrl.sv
// Sequencer for the up/down counter: load a start value, sweep up to full scale,
// sweep down to zero for a programmed number of passes, and verify every commanded step.
module counter_sweep_ctrl #(
    parameter int WIDTH  = 4,
    parameter int PASS_W = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic              abort,
    input  logic              pause,
    input  logic [WIDTH-1:0]  start_value,
    input  logic [PASS_W-1:0] passes,
    input  logic [WIDTH-1:0]  count_out,
    input  logic              max_count,
    input  logic              zero,
    output logic              load_n,
    output logic              up_down,
    output logic              ce,
    output logic [WIDTH-1:0]  data_load,
    output logic              busy,
    output logic              done,
    output logic              step_err,
    output logic [2:0]        state_dbg
);

    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_LOAD = 3'd1,
        S_UP   = 3'd2,
        S_DOWN = 3'd3,
        S_DONE = 3'd4
    } state_t;

    state_t            state;
    state_t            state_next;
    logic [WIDTH-1:0]  cap_value;
    logic [PASS_W-1:0] pass_left;
    logic [PASS_W-1:0] pass_left_next;
    logic              accept;

    logic              chk_valid;
    logic              chk_load;
    logic              chk_ce;
    logic              chk_up;
    logic [WIDTH-1:0]  chk_prev;
    logic [WIDTH-1:0]  chk_expect;
    logic              mismatch;

    // start is a single-cycle request; it is accepted only when the FSM sits in IDLE.
    assign accept    = (state == S_IDLE) && start;
    assign data_load = cap_value;
    assign state_dbg = state;

    always_comb begin
        state_next     = state;
        pass_left_next = pass_left;
        load_n         = 1'b1;
        up_down        = 1'b1;
        ce             = 1'b0;
        busy           = 1'b0;
        done           = 1'b0;
        case (state)
            S_IDLE: begin
                if (start) state_next = S_LOAD;
            end
            S_LOAD: begin
                load_n     = 1'b0;
                busy       = 1'b1;
                state_next = S_UP;
            end
            S_UP: begin
                busy = 1'b1;
                ce   = !pause && !max_count && !abort;
                if (max_count) state_next = S_DOWN;
            end
            S_DOWN: begin
                busy    = 1'b1;
                up_down = 1'b0;
                ce      = !pause && !zero && !abort;
                if (zero) begin
                    if (pass_left == PASS_W'(1)) begin
                        state_next = S_DONE;
                    end else begin
                        pass_left_next = pass_left - PASS_W'(1);
                        state_next     = S_UP;
                    end
                end
            end
            S_DONE: begin
                done       = 1'b1;
                state_next = S_IDLE;
            end
            default: state_next = S_IDLE;
        endcase
        // Abort also gates ce so the counter holds the value it had when abort arrived.
        if (abort && (state != S_IDLE)) begin
            state_next     = S_IDLE;
            pass_left_next = pass_left;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= S_IDLE;
            cap_value <= '0;
            pass_left <= '0;
        end else begin
            state <= state_next;
            if (accept) begin
                cap_value <= start_value;
                pass_left <= (passes == '0) ? PASS_W'(1) : passes;
            end else begin
                pass_left <= pass_left_next;
            end
        end
    end

    // Step checker: remember what was commanded this cycle, compare the counter next cycle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            chk_valid <= 1'b0;
            chk_load  <= 1'b0;
            chk_ce    <= 1'b0;
            chk_up    <= 1'b1;
            chk_prev  <= '0;
        end else begin
            chk_valid <= busy;
            chk_load  <= !load_n;
            chk_ce    <= ce;
            chk_up    <= up_down;
            chk_prev  <= count_out;
        end
    end

    always_comb begin
        chk_expect = chk_prev;
        if (chk_load) begin
            chk_expect = cap_value;
        end else if (chk_ce) begin
            chk_expect = chk_up ? (chk_prev + WIDTH'(1)) : (chk_prev - WIDTH'(1));
        end
    end

    assign mismatch = chk_valid && (count_out != chk_expect);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            step_err <= 1'b0;
        end else if (accept) begin
            step_err <= 1'b0;
        end else if (mismatch) begin
            step_err <= 1'b1;
        end
    end

endmodule

// File: tb/tb_counter_sweep_ctrl.sv
// Directed bench for counter_sweep_ctrl with a behavioural up/down counter beside it;
// the counter can be told to skip 2->4 while counting up.
module tb_counter_sweep_ctrl;

    localparam int WIDTH  = 4;
    localparam int PASS_W = 8;

    logic              clk;
    logic              rst_n;
    logic              start;
    logic              abort;
    logic              pause;
    logic [WIDTH-1:0]  start_value;
    logic [PASS_W-1:0] passes;
    logic [WIDTH-1:0]  cnt;
    logic              max_count;
    logic              zero;
    logic              load_n;
    logic              up_down;
    logic              ce;
    logic [WIDTH-1:0]  data_load;
    logic              busy;
    logic              done;
    logic              step_err;
    logic [2:0]        state_dbg;
    logic              fault;

    int n_checks;
    int n_pass;

    logic [WIDTH-1:0] cnt_hist [128];
    logic             ce_hist  [128];
    logic             err_hist [128];
    logic [WIDTH-1:0] exp_q [$];
    int r_up_ce, r_down_ce, r_bubbles, r_done_k, r_done_pulses, r_busy, r_hold;
    logic r_loadn0;
    logic [WIDTH-1:0] r_dl0;

    counter_sweep_ctrl #(.WIDTH(WIDTH), .PASS_W(PASS_W)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .abort(abort), .pause(pause),
        .start_value(start_value), .passes(passes), .count_out(cnt),
        .max_count(max_count), .zero(zero), .load_n(load_n), .up_down(up_down),
        .ce(ce), .data_load(data_load), .busy(busy), .done(done),
        .step_err(step_err), .state_dbg(state_dbg)
    );

    // clock / reset block
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // behavioural counter sharing rst_n with the sequencer
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt <= '0;
        end else if (!load_n) begin
            cnt <= data_load;
        end else if (ce) begin
            if (up_down) cnt <= (fault && cnt == 4'd2) ? 4'd4 : cnt + 4'd1;
            else         cnt <= cnt - 4'd1;
        end
    end
    assign max_count = &cnt;
    assign zero      = (cnt == '0);

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    endtask

    // Issue start, then observe n_cyc cycles; cycle k is the one following edge Ek.
    task automatic run_seq(input logic [WIDTH-1:0] sv, input logic [PASS_W-1:0] np,
                           input int n_cyc, input int pause_k, input int pause_len,
                           input int abort_k);
        start_value = sv;
        passes      = np;
        start       = 1'b1;
        @(posedge clk); #1;
        start       = 1'b0;
        start_value = ~sv;
        passes      = 8'd5;
        r_up_ce = 0; r_down_ce = 0; r_bubbles = 0; r_done_k = -1;
        r_done_pulses = 0; r_busy = 0; r_hold = 0;
        for (int k = 0; k < n_cyc; k++) begin
            pause = (k >= pause_k) && (k < pause_k + pause_len);
            abort = (k == abort_k);
            @(negedge clk);
            cnt_hist[k] = cnt;
            ce_hist[k]  = ce;
            err_hist[k] = step_err;
            if (k == 0) begin
                r_loadn0 = load_n;
                r_dl0    = data_load;
            end
            if (ce && up_down)  r_up_ce++;
            if (ce && !up_down) r_down_ce++;
            if (busy && load_n && up_down && max_count) r_bubbles++;
            if (busy) r_busy++;
            if (done) begin
                if (r_done_k < 0) r_done_k = k;
                r_done_pulses++;
            end
            if (pause && !ce && cnt == 4'd7) r_hold++;
            @(posedge clk); #1;
        end
        pause = 1'b0;
        abort = 1'b0;
    endtask

    initial begin
        n_checks = 0; n_pass = 0;
        rst_n = 1'b0; start = 1'b0; abort = 1'b0; pause = 1'b0; fault = 1'b0;
        start_value = '0; passes = '0;
        repeat (2) @(posedge clk);
        #1;
        check("rst_load_n", load_n, 1);
        check("rst_up_down", up_down, 1);
        check("rst_ce", ce, 0);
        check("rst_data_load", data_load, 0);
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_step_err", step_err, 0);
        check("rst_state", state_dbg, 0);
        rst_n = 1'b1;
        @(posedge clk); #1;

        // single pass from 3
        run_seq(4'd3, 8'd1, 33, -1, 0, -1);
        check("sp_load_n_k0", r_loadn0, 0);
        check("sp_data_load_k0", r_dl0, 3);
        check("sp_up_ce", r_up_ce, 12);
        check("sp_down_ce", r_down_ce, 15);
        check("sp_bubbles", r_bubbles, 1);
        check("sp_done_k", r_done_k, 30);
        check("sp_done_pulses", r_done_pulses, 1);
        check("sp_busy_cycles", r_busy, 30);
        check("sp_step_err", step_err, 0);
        check("sp_idle", state_dbg, 0);
        for (int k = 1; k <= 13; k++) exp_q.push_back(WIDTH'(k + 2));
        for (int k = 14; k <= 29; k++) exp_q.push_back(WIDTH'(29 - k));
        for (int k = 1; k <= 29; k++) check($sformatf("sp_count_k%0d", k), cnt_hist[k], exp_q.pop_front());

        // three passes from 0
        run_seq(4'd0, 8'd3, 100, -1, 0, -1);
        check("mp_up_ce", r_up_ce, 45);
        check("mp_down_ce", r_down_ce, 45);
        check("mp_bubbles", r_bubbles, 3);
        check("mp_done_k", r_done_k, 97);
        check("mp_done_pulses", r_done_pulses, 1);
        check("mp_step_err", step_err, 0);

        // passes = 0 behaves as one pass
        run_seq(4'd0, 8'd0, 36, -1, 0, -1);
        check("p0_bubbles", r_bubbles, 1);
        check("p0_done_k", r_done_k, 33);
        check("p0_done_pulses", r_done_pulses, 1);

        // pause 5 cycles in UP at count 7
        run_seq(4'd3, 8'd1, 38, 5, 5, -1);
        check("pz_hold", r_hold, 5);
        check("pz_count_k10", cnt_hist[10], 7);
        check("pz_up_ce", r_up_ce, 12);
        check("pz_done_k", r_done_k, 35);
        check("pz_step_err", step_err, 0);

        // abort during DOWN at count 9
        run_seq(4'd3, 8'd1, 40, -1, 0, 20);
        check("ab_count_k20", cnt_hist[20], 9);
        check("ab_ce_k20", ce_hist[20], 0);
        check("ab_busy_cycles", r_busy, 21);
        check("ab_done_pulses", r_done_pulses, 0);
        check("ab_count_end", cnt, 9);
        check("ab_busy_end", busy, 0);
        check("ab_ce_end", ce, 0);
        check("ab_state", state_dbg, 0);

        // counter skips 2->4 while counting up
        fault = 1'b1;
        run_seq(4'd0, 8'd1, 35, -1, 0, -1);
        fault = 1'b0;
        check("ft_count_k4", cnt_hist[4], 4);
        check("ft_err_k4", err_hist[4], 0);
        check("ft_err_k5", err_hist[5], 1);
        check("ft_done_k", r_done_k, 32);
        check("ft_err_at_done", err_hist[32], 1);
        check("ft_err_end", step_err, 1);

        // next start clears the sticky error
        run_seq(4'd5, 8'd1, 30, -1, 0, -1);
        check("cl_err_k0", err_hist[0], 0);
        check("cl_done_k", r_done_k, 28);
        check("cl_err_end", step_err, 0);

        // asynchronous reset mid-UP, with the error flag set beforehand
        fault = 1'b1;
        run_seq(4'd0, 8'd1, 8, -1, 0, -1);
        fault = 1'b0;
        check("ar_err_before", step_err, 1);
        check("ar_ce_before", ce, 1);
        #2;
        rst_n = 1'b0;
        #1;
        check("ar_load_n", load_n, 1);
        check("ar_up_down", up_down, 1);
        check("ar_ce", ce, 0);
        check("ar_data_load", data_load, 0);
        check("ar_busy", busy, 0);
        check("ar_done", done, 0);
        check("ar_step_err", step_err, 0);
        check("ar_state", state_dbg, 0);
        check("ar_count", cnt, 0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(posedge clk); #1;

        // full-scale start value: immediate bubble then DOWN
        run_seq(4'hF, 8'd1, 21, -1, 0, -1);
        check("fs_data_load_k0", r_dl0, 15);
        check("fs_count_k1", cnt_hist[1], 15);
        check("fs_ce_k1", ce_hist[1], 0);
        check("fs_up_ce", r_up_ce, 0);
        check("fs_bubbles", r_bubbles, 1);
        check("fs_down_ce", r_down_ce, 15);
        check("fs_done_k", r_done_k, 18);
        check("fs_step_err", step_err, 0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/counter_sweep_ctrl.md
# counter_sweep_ctrl

Hardware sequencer that drives the control side of the up/down counter: `load_n`, `up_down`, `ce`, `data_load`. It consumes the counter's `count_out`, `max_count` and `zero` status. On `start` it loads a start value, counts up to full scale, then down to zero, and repeats for a programmed number of passes. It also checks every counter step it commands and records any mismatch. It sits beside the counter on the same clock as its autonomous stimulus source.

## Interface
- `WIDTH`, default 4: counter width; must match the counter instance.
- `PASS_W`, default 8: width of the pass-count input.

Ports:
- `clk`  in  1  system clock; all activity on the rising edge.
- `rst_n`  in  1  asynchronous active-low reset.
- `start`  in  1  begin a sequence; honoured in IDLE only.
- `abort`  in  1  terminate the sequence.
- `pause`  in  1  hold; forces `ce`=0, state frozen.
- `start_value`  in  WIDTH  value loaded into the counter.
- `passes`  in  PASS_W  number of up/down passes; 0 is treated as 1.
- `count_out`  in  WIDTH  counter value.
- `max_count`  in  1  counter at all-ones.
- `zero`  in  1  counter at 0.
- `load_n`  out  1  counter load, active low.
- `up_down`  out  1  1 = up, 0 = down.
- `ce`  out  1  counter enable.
- `data_load`  out  WIDTH  counter load value.
- `busy`  out  1  sequence in progress.
- `done`  out  1  one-cycle completion pulse.
- `step_err`  out  1  sticky; set on a counter step mismatch.

## Operation
- The counter's own `rst_n` is tied to the same `rst_n`; this block never resets the counter.
- `start_value` and `passes` are captured on the accepting `start` edge; later input changes are ignored.
- States are IDLE, LOAD, UP, DOWN and DONE.
- IDLE:
  - Drives `load_n`=1, `ce`=0, `up_down`=1.
  - `start` moves to LOAD and clears `step_err`.
- LOAD (exactly one cycle):
  - Drives `load_n`=0, `data_load`=captured value, `ce`=0.
  - Always goes to UP.
- UP:
  - `up_down`=1.
  - `ce` = !`pause` && !`max_count`.
  - `max_count`=1 moves to DOWN, giving one bubble cycle with `ce`=0 at the turn.
- DOWN:
  - `up_down`=0.
  - `ce` = !`pause` && !`zero`.
  - `zero`=1 with remaining passes equal to 1 moves to DONE.
  - `zero`=1 otherwise decrements remaining passes and moves to UP.
- DONE: `done`=1 for one cycle, then IDLE.
- `abort` in any state other than IDLE:
  - Goes to IDLE on the next edge and has priority over all transitions.
  - No `done` pulse.
  - `step_err` retained.
- `pause` freezes state. Transitions on `max_count`/`zero` are still taken while paused, because `ce` is already 0 in those cycles.
- `busy` = 1 in LOAD, UP and DOWN.
- Step checker:
  - Registers the commanded action each cycle.
  - The cycle after a LOAD command, `count_out` must equal the captured value.
  - After `ce` with up, `count_out` must equal previous + 1 mod 2^WIDTH.
  - After `ce` with down, `count_out` must equal previous − 1 mod 2^WIDTH.
  - After `ce`=0, `count_out` must be unchanged.
  - Any mismatch sets `step_err` until the next accepted `start` or reset.
  - The check is active only while `busy` was 1 in the commanding cycle.

## Timing
- Reset values: state IDLE, `load_n`=1, `up_down`=1, `ce`=0, `data_load`=0, `busy`=0, `done`=0, `step_err`=0, remaining passes 0.
- Reset asserted mid-sequence drops all outputs to their reset values immediately, not waiting for a clock edge.
- All control outputs are decoded from registered state plus the current `pause`/`max_count`/`zero` inputs. Each counter action lands on the edge ending the cycle in which it is commanded.
- Start latency: with `start` sampled at edge E0, LOAD is the cycle E0–E1, the counter holds the value after E1, and UP begins at E1.
- `start_value` = all-ones: UP lasts one cycle with `ce`=0, then DOWN.
- `start_value` = 0: counting runs normally; the first `zero` check occurs only in DOWN.
- `start` while busy is ignored.
- `start` and `abort` together in IDLE: `start` wins.

## Test plan
- **Single pass from 3:** WIDTH=4, `start_value`=3, `passes`=1, `start` at E0.
  - Load cycle; 12 up `ce` cycles, with 15 reached at E13.
  - Bubble; DOWN from E14 with 15 `ce` cycles, reaching 0 at E29.
  - `done` high E30–E31; `busy` low from E30; `step_err`=0.
- **Multi-pass:** `passes`=3, `start_value`=0.
  - Exactly three up/down sweeps, three `max_count` bubbles, one `done` pulse.
  - `passes`=0 gives one sweep.
- **Pause:** `pause` held 5 cycles during UP at count 7.
  - `ce`=0 and count held at 7 for 5 cycles; sequence then resumes; total length +5; no `step_err`.
- **Abort:** `abort` during DOWN at count 9.
  - IDLE next edge, `ce`=0, `busy`=0, no `done`; counter remains at 9.
- **Faulty counter:** model forced to skip (2→4) during UP.
  - `step_err`=1 one cycle later and stays set through `done`.
  - `step_err` clears on the next `start`.
- **Async reset:** `rst_n` asserted mid-UP, between edges.
  - All outputs at reset values immediately.
  - After release, `start` runs a clean sequence with `start_value` = all-ones: immediate bubble, then DOWN.
